// File: rtl/tone_generator_pkg.sv
// Shared definitions for the tone generator and the PS/2 note decoder:
// widths, filter defaults, FSM encoding and the note half-period table.
package tone_generator_pkg;

   localparam int TONE_WIDTH         = 26;
   localparam int TONE_STABLE_CYCLES = 4;
   localparam int TONE_MIN_HALF      = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } toneState_t;

   // Half-periods in CLK cycles for a 50 MHz clock, Do1 = C4 (261.63 Hz).
   localparam logic [TONE_WIDTH-1:0] DO1  = 26'd95_555;
   localparam logic [TONE_WIDTH-1:0] RE1  = 26'd85_132;
   localparam logic [TONE_WIDTH-1:0] MI1  = 26'd75_843;
   localparam logic [TONE_WIDTH-1:0] FA1  = 26'd71_586;
   localparam logic [TONE_WIDTH-1:0] SOL1 = 26'd63_775;
   localparam logic [TONE_WIDTH-1:0] LA1  = 26'd56_818;
   localparam logic [TONE_WIDTH-1:0] SI1  = 26'd50_619;
   localparam logic [TONE_WIDTH-1:0] DO2  = 26'd47_778;
   localparam logic [TONE_WIDTH-1:0] RE2  = 26'd42_565;
   localparam logic [TONE_WIDTH-1:0] MI2  = 26'd37_921;
   localparam logic [TONE_WIDTH-1:0] FA2  = 26'd35_793;
   localparam logic [TONE_WIDTH-1:0] SOL2 = 26'd31_888;
   localparam logic [TONE_WIDTH-1:0] LA2  = 26'd28_409;
   localparam logic [TONE_WIDTH-1:0] SI2  = 26'd25_309;
   localparam logic [TONE_WIDTH-1:0] DO3  = 26'd23_889;
   localparam logic [TONE_WIDTH-1:0] RE3  = 26'd21_282;
   localparam logic [TONE_WIDTH-1:0] MI3  = 26'd18_960;
   localparam logic [TONE_WIDTH-1:0] FA3  = 26'd17_896;
   localparam logic [TONE_WIDTH-1:0] SOL3 = 26'd15_944;
   localparam logic [TONE_WIDTH-1:0] LA3  = 26'd14_204;
   localparam logic [TONE_WIDTH-1:0] SI3  = 26'd12_654;
   localparam logic [TONE_WIDTH-1:0] DO4  = 26'd11_944;
   localparam logic [TONE_WIDTH-1:0] RE4  = 26'd10_641;
   localparam logic [TONE_WIDTH-1:0] MI4  = 26'd9_480;
   localparam logic [TONE_WIDTH-1:0] FA4  = 26'd8_948;
   localparam logic [TONE_WIDTH-1:0] SOL4 = 26'd7_972;
   localparam logic [TONE_WIDTH-1:0] LA4  = 26'd7_102;
   localparam logic [TONE_WIDTH-1:0] SI4  = 26'd6_327;

endpackage

// File: rtl/tone_generator_if.sv
// Note/enable inputs and speaker status outputs of the tone generator.
// master = note source (decoder side), slave = tone generator.
interface tone_generator_if #(
   parameter int WIDTH = tone_generator_pkg::TONE_WIDTH
);

   logic [WIDTH-1:0] note_in;
   logic             enable;
   logic             speaker;
   logic             playing;
   logic [WIDTH-1:0] cur_period;

   modport master (
      output note_in,
      output enable,
      input  speaker,
      input  playing,
      input  cur_period
   );

   modport slave (
      input  note_in,
      input  enable,
      output speaker,
      output playing,
      output cur_period
   );

endinterface

// File: rtl/tone_generator_note_stabilizer.sv
// Accepts a note value only after it has been held on consecutive CLK edges;
// values below MIN_HALF are accepted as silence.
module note_stabilizer
   import tone_generator_pkg::*;
#(
   parameter int WIDTH         = TONE_WIDTH,
   parameter int STABLE_CYCLES = TONE_STABLE_CYCLES,
   parameter int MIN_HALF      = TONE_MIN_HALF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_noteIn,
   output logic [WIDTH-1:0] o_accPeriod
);

   localparam int CW = $clog2(STABLE_CYCLES);

   logic [WIDTH-1:0] r_cand;
   logic [WIDTH-1:0] r_accPeriod;
   logic [CW-1:0]    r_stabCnt;

   // Any change restarts the count, so slow-clock transitions are never latched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cand      <= '0;
         r_stabCnt   <= '0;
         r_accPeriod <= '0;
      end else if (i_noteIn != r_cand) begin
         r_cand    <= i_noteIn;
         r_stabCnt <= '0;
      end else if (r_stabCnt < CW'(STABLE_CYCLES - 1)) begin
         r_stabCnt <= r_stabCnt + CW'(1);
      end else begin
         r_accPeriod <= (r_cand < WIDTH'(MIN_HALF)) ? '0 : r_cand;
      end
   end

   assign o_accPeriod = r_accPeriod;

endmodule

// File: rtl/tone_generator.sv
// Square-wave speaker driver: plays the filtered half-period and only switches
// notes at full-period boundaries so no runt pulses reach the speaker.
module tone_generator
   import tone_generator_pkg::*;
#(
   parameter int WIDTH         = TONE_WIDTH,
   parameter int STABLE_CYCLES = TONE_STABLE_CYCLES,
   parameter int MIN_HALF      = TONE_MIN_HALF
) (
   input  logic            CLK,
   input  logic            RST_N,
   tone_generator_if.slave bus
);

   logic [WIDTH-1:0] w_accPeriod;
   logic             w_go;

   toneState_t       r_state;
   logic             r_speaker;
   logic [WIDTH-1:0] r_curPeriod;
   logic [WIDTH-1:0] r_halfCnt;

   toneState_t       w_stateNext;
   logic             w_speakerNext;
   logic [WIDTH-1:0] w_curPeriodNext;
   logic [WIDTH-1:0] w_halfCntNext;
   logic             w_phaseEnd;

   note_stabilizer #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES),
      .MIN_HALF      (MIN_HALF)
   ) u_stabilizer (
      .clk         (CLK),
      .rst_n       (RST_N),
      .i_noteIn    (bus.note_in),
      .o_accPeriod (w_accPeriod)
   );

   assign w_go       = bus.enable && (w_accPeriod != '0);
   assign w_phaseEnd = (r_halfCnt == r_curPeriod - WIDTH'(1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= IDLE;
         r_speaker   <= 1'b0;
         r_curPeriod <= '0;
         r_halfCnt   <= '0;
      end else begin
         r_state     <= w_stateNext;
         r_speaker   <= w_speakerNext;
         r_curPeriod <= w_curPeriodNext;
         r_halfCnt   <= w_halfCntNext;
      end
   end

   // A new period is picked up only when a LOW phase ends, keeping duty at 50%.
   always_comb begin
      w_stateNext     = r_state;
      w_speakerNext   = r_speaker;
      w_curPeriodNext = r_curPeriod;
      w_halfCntNext   = r_halfCnt;
      case (r_state)
         IDLE: begin
            w_speakerNext = 1'b0;
            w_halfCntNext = '0;
            if (w_go) begin
               w_curPeriodNext = w_accPeriod;
               w_speakerNext   = 1'b1;
               w_stateNext     = HIGH;
            end
         end
         HIGH: begin
            w_halfCntNext = r_halfCnt + WIDTH'(1);
            if (w_phaseEnd) begin
               w_halfCntNext = '0;
               w_speakerNext = 1'b0;
               if (!w_go) begin
                  w_stateNext     = IDLE;
                  w_curPeriodNext = '0;
               end else begin
                  w_stateNext = LOW;
               end
            end
         end
         LOW: begin
            w_halfCntNext = r_halfCnt + WIDTH'(1);
            if (w_phaseEnd) begin
               w_halfCntNext = '0;
               if (!w_go) begin
                  w_stateNext     = IDLE;
                  w_curPeriodNext = '0;
               end else begin
                  w_curPeriodNext = w_accPeriod;
                  w_speakerNext   = 1'b1;
                  w_stateNext     = HIGH;
               end
            end
         end
         default: begin
            w_stateNext     = IDLE;
            w_speakerNext   = 1'b0;
            w_curPeriodNext = '0;
            w_halfCntNext   = '0;
         end
      endcase
   end

   assign bus.speaker    = r_speaker;
   assign bus.playing    = (r_state != IDLE);
   assign bus.cur_period = r_curPeriod;

endmodule

// File: tb/tb_tone_generator.sv
// Randomized bench for tone_generator, checked every cycle against a
// timestamp-based phase model fed by a sliding-window note filter.
module tb_tone_generator;
   import tone_generator_pkg::*;

   localparam int W      = TONE_WIDTH;
   localparam int STABLE = 4;
   localparam int MINH   = 16;

   logic CLK;
   logic RST_N;

   tone_generator_if #(.WIDTH(W)) toneIf();

   tone_generator #(
      .WIDTH         (W),
      .STABLE_CYCLES (STABLE),
      .MIN_HALF      (MINH)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (toneIf)
   );

   int unsigned checkCount;
   int unsigned passCount;
   longint      cycle;

   int unsigned mHist[$];
   int unsigned mAcc;
   int unsigned mPeriod;
   bit          mIdle;
   bit          mLevel;
   longint      mPhaseEnd;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reset leaves the filter candidate at 0, which counts as one prior sample.
   function automatic void modelReset();
      mHist.delete();
      mHist.push_back(0);
      mAcc      = 0;
      mPeriod   = 0;
      mIdle     = 1'b1;
      mLevel    = 1'b0;
      mPhaseEnd = 0;
   endfunction

   // One CLK edge: the tone side sees the accepted note from before this edge.
   function automatic void modelStep(input int unsigned note, input bit en);
      bit go;
      bit same;
      go = en && (mAcc != 0);
      if (mIdle) begin
         if (go) begin
            mIdle     = 1'b0;
            mLevel    = 1'b1;
            mPeriod   = mAcc;
            mPhaseEnd = cycle + longint'(mPeriod);
         end
      end else if (cycle == mPhaseEnd) begin
         if (mLevel) begin
            mLevel = 1'b0;
            if (!go) begin
               mIdle   = 1'b1;
               mPeriod = 0;
            end else begin
               mPhaseEnd = cycle + longint'(mPeriod);
            end
         end else if (!go) begin
            mIdle   = 1'b1;
            mPeriod = 0;
         end else begin
            mPeriod   = mAcc;
            mLevel    = 1'b1;
            mPhaseEnd = cycle + longint'(mPeriod);
         end
      end
      mHist.push_back(note);
      if (mHist.size() > STABLE + 1) void'(mHist.pop_front());
      if (mHist.size() == STABLE + 1) begin
         same = 1'b1;
         foreach (mHist[i]) if (mHist[i] != note) same = 1'b0;
         if (same) mAcc = (note < MINH) ? 0 : note;
      end
   endfunction

   task automatic checkOutput();
      checkCount++;
      assert (toneIf.speaker === mLevel) passCount++;
      else $error("[TB] FAIL speaker @%0d: observed %0b expected %0b", cycle, toneIf.speaker, mLevel);
      checkCount++;
      assert (toneIf.playing === !mIdle) passCount++;
      else $error("[TB] FAIL playing @%0d: observed %0b expected %0b", cycle, toneIf.playing, !mIdle);
      checkCount++;
      assert (toneIf.cur_period === W'(mPeriod)) passCount++;
      else $error("[TB] FAIL cur_period @%0d: observed %0d expected %0d", cycle, toneIf.cur_period, mPeriod);
   endtask

   task automatic tick();
      @(posedge CLK);
      cycle++;
      modelStep(32'(toneIf.note_in), toneIf.enable);
      #1;
      checkOutput();
   endtask

   task automatic applyStimulus(input int unsigned note, input bit en, input int cycles);
      toneIf.note_in = W'(note);
      toneIf.enable  = en;
      repeat (cycles) tick();
   endtask

   task automatic waitSpeaker(input bit level, input int budget);
      int k;
      k = 0;
      while (toneIf.speaker !== level && k < budget) begin
         tick();
         k++;
      end
      checkCount++;
      assert (toneIf.speaker === level) passCount++;
      else $error("[TB] FAIL wait_speaker: observed %0b expected %0b within %0d cycles", toneIf.speaker, level, budget);
   endtask

   // Asynchronous reset while the speaker is high must clear it without a CLK edge.
   task automatic pulseResetMidHigh();
      #2;
      RST_N = 1'b0;
      modelReset();
      #1;
      checkOutput();
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   initial begin
      int riseAt;
      checkCount    = 0;
      passCount     = 0;
      cycle         = 0;
      RST_N         = 1'b0;
      toneIf.note_in = W'(95_555);
      toneIf.enable  = 1'b1;
      modelReset();
      #12;
      checkOutput();
      repeat (2) @(posedge CLK);
      checkOutput();
      #1;
      RST_N = 1'b1;

      riseAt = 0;
      while (toneIf.speaker !== 1'b1 && riseAt < 20) begin
         tick();
         riseAt++;
      end
      checkCount++;
      assert (riseAt == STABLE + 2) passCount++;
      else $error("[TB] FAIL first_rise: observed %0d cycles expected %0d", riseAt, STABLE + 2);
      applyStimulus(95_555, 1'b1, 3);
      pulseResetMidHigh();

      applyStimulus(20, 1'b1, 120);

      applyStimulus(40, 1'b1, 3);
      applyStimulus(20, 1'b1, 80);

      waitSpeaker(1'b0, 60);
      waitSpeaker(1'b1, 60);
      applyStimulus(20, 1'b1, 5);
      applyStimulus(30, 1'b1, 200);

      waitSpeaker(1'b1, 80);
      waitSpeaker(1'b0, 80);
      applyStimulus(30, 1'b1, 5);
      applyStimulus(0, 1'b1, 60);
      applyStimulus(10, 1'b1, 40);

      applyStimulus(25, 1'b1, 0);
      waitSpeaker(1'b1, 40);
      applyStimulus(25, 1'b1, 5);
      applyStimulus(25, 1'b0, 50);
      applyStimulus(25, 1'b1, 60);

      for (int s = 0; s < 40; s++) begin
         int unsigned note;
         bit          en;
         case ($urandom_range(0, 9))
            0:       note = 0;
            1:       note = $urandom_range(1, MINH - 1);
            2:       note = MINH;
            default: note = $urandom_range(MINH, 48);
         endcase
         en = ($urandom_range(0, 7) != 0);
         applyStimulus(note, en, $urandom_range(1, 70));
      end

      applyStimulus(22, 1'b1, 0);
      waitSpeaker(1'b1, 200);
      pulseResetMidHigh();
      applyStimulus(22, 1'b1, 80);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
